hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps its own shadow pipeline of destination/Tnew/result-source records for E, M and W.
- Each cycle it drives the select codes of the D-, E- and M-stage forwarding muxes, plus the stall/bubble controls.
- Sits beside the decoder; consumes decoded D-stage fields only.

Parameters:
- AW, 5, register-address width.
- TW, 2, width of Tuse/Tnew fields.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rs_d  in  AW  rs index of instruction in D.
- rt_d  in  AW  rt index of instruction in D.
- use_rs_d  in  1  D instruction reads rs.
- use_rt_d  in  1  D instruction reads rt.
- tuse_rs_d  in  TW  cycles until rs needed (0=D, 1=E, 2=M).
- tuse_rt_d  in  TW  same for rt.
- dst_d  in  AW  destination register (0 = no write).
- tnew_d  in  TW  cycles after entering E until result is forwardable (ALU/jal=1, load=2).
- wsrc_d  in  2  result source: 00 ALU, 01 DM, 10 PC+8.
- stall  out  1  freeze PC and F/D register.
- flush_e  out  1  load bubble into D/E register.
- mf_rs_d_op  out  2  D-stage rs mux select.
- mf_rt_d_op  out  2  D-stage rt mux select.
- mf_rs_e_op  out  2  E-stage rs mux select.
- mf_rt_e_op  out  2  E-stage rt mux select.
- mf_rt_m_op  out  2  M-stage rt mux select; bit 1 always 0.

Behaviour:
- Select encoding (D/E muxes):
  - 00 register-file / pipeline value.
  - 01 ALU result in M.
  - 10 PC4_M+4, i.e. PC+8 in M.
  - 11 WData from W.
- M-mux encoding: 00 RD2_M, 01 WData.
- Shadow registers:
  - E: rs, rt, dst, tnew, wsrc.
  - M: rt, dst, tnew, wsrc.
  - W: dst.
- All shadows advance on every rising clk.
  - E loads from D inputs, or loads a bubble (all fields 0) when stall=1.
  - M loads from E with tnew_m = (tnew_e==0) ? 0 : tnew_e-1.
  - W loads dst_m.
- Reset (async, reset=0): all shadows cleared. Outputs then read stall=0, flush_e=0, all selects 00. Release takes effect at the next clk edge.
- Match rule: a stage matches a source when its dst equals the source register AND dst != 0. Register 0 is never forwarded or stalled on.
- Forwardable sources:
  - M, only when tnew_m==0 and wsrc_m is 00 or 10. ALU gives 01, PC+8 gives 10.
  - W, always; gives 11.
  - E is never a forward source.
- Priority: M over W; the youngest producer wins.
- D-stage select: evaluated against M then W using rs_d/rt_d.
- E-stage select: evaluated against M then W using rs_e/rt_e.
- M-stage rt select: 01 iff dst_w matches rt_m, else 00.
- stall (combinational), set when any of the following holds:
  - use_rs_d and E matches rs_d and tnew_e > tuse_rs_d;
  - use_rs_d and M matches rs_d and tnew_m > tuse_rs_d;
  - the same two conditions for rt.
- flush_e = stall. PC/D freeze and E bubble happen in the same cycle.
- Selects are still driven during a stall; the bubble makes the E-stage selects harmless the next cycle.
- Latency: all outputs combinational from current D inputs plus shadows. No extra cycle.
- Load-use (tnew_e=2, tuse=1): exactly 1 stall cycle.
- Load then branch (tuse=0): 2 stall cycles.
- ALU then branch: 1 stall cycle.
- Reset mid-stall: stall drops immediately; the in-flight instructions are discarded by the core reset.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - adds output stall_cnt [31:0];
  - it increments on each clk where stall=1, saturates at 0xFFFFFFFF, and clears on reset.
- When undefined: the port and the counter are absent. Behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU then use: addu $3 in D, next cycle subu reading $3 in E → mf_rs_e_op=01, stall=0.
- Two-apart dependency: producer $5 in W, consumer in E reading $5 → mf_rs_e_op=11.
- Same register in both M and W: dst_m=dst_w=$5 → 01 chosen.
- Load-use: lw $4 in E (tnew 2), addu reading $4 with tuse 1 in D → stall=1, flush_e=1 for 1 cycle. Next cycle the consumer's E select is 11.
- Store after load:
  - lw $6 then sw $6 (tuse_rt 2) → no stall;
  - at M, mf_rt_m_op=01.
- Branch after jal:
  - jal (dst 31, wsrc 10) then beq on $31 → 1 stall cycle, then mf_rs_d_op=10.
  - $0 producer → all selects 00, stall=0.
- Reset asserted during a load-use stall: stall=0 and all selects 00 immediately.
- With HAZARD_STALL_CNT_EN: stall_cnt=0 after reset, then 3 after load-branch plus ALU-branch.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard detection and forwarding control for a 5-stage MIPS pipeline
// (F/D/E/M/W). The block keeps a shadow copy of the destination register,
// Tnew and result-source fields of the instructions in E, M and W. From those
// shadows and the decoded fields of the instruction in D, it drives the
// forwarding mux selects and the stall/bubble controls, all combinationally.
//
// Optional feature (compile-time macro HAZARD_STALL_CNT_EN):
//   adds output stall_cnt, a saturating count of clock edges seen with
//   stall=1. It is cleared by reset. When the macro is undefined the port and
//   the counter do not exist.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   rs_d/rt_d   in   source register indices of the D instruction
//   use_rs_d    in   D instruction reads rs
//   use_rt_d    in   D instruction reads rt
//   tuse_rs_d   in   cycles until rs is needed (0=D, 1=E, 2=M)
//   tuse_rt_d   in   same for rt
//   dst_d       in   destination register (0 = no write)
//   tnew_d      in   cycles after entering E until the result is forwardable
//   wsrc_d      in   result source: 00 ALU, 01 DM, 10 PC+8
//   stall       out  freeze PC and the F/D register
//   flush_e     out  load a bubble into the D/E register
//   mf_rs_d_op  out  D-stage rs mux select
//   mf_rt_d_op  out  D-stage rt mux select
//   mf_rs_e_op  out  E-stage rs mux select
//   mf_rt_e_op  out  E-stage rt mux select
//   mf_rt_m_op  out  M-stage rt mux select (bit 1 always 0)
//   stall_cnt   out  stall cycle counter (only with HAZARD_STALL_CNT_EN)
//
// D/E select encoding: 00 register/pipeline value, 01 ALU result in M,
// 10 PC+8 in M, 11 WData from W. M select: 00 RD2_M, 01 WData.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          use_rs_d,
    input  logic          use_rt_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [AW-1:0] dst_d,
    input  logic [TW-1:0] tnew_d,
    input  logic [1:0]    wsrc_d,
    output logic          stall,
    output logic          flush_e,
    output logic [1:0]    mf_rs_d_op,
    output logic [1:0]    mf_rt_d_op,
    output logic [1:0]    mf_rs_e_op,
    output logic [1:0]    mf_rt_e_op,
    output logic [1:0]    mf_rt_m_op
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    // Result source of a producer.
    typedef enum logic [1:0] {
        WSRC_ALU = 2'b00,
        WSRC_DM  = 2'b01,
        WSRC_PC8 = 2'b10
    } wsrc_e;

    // D/E forwarding mux select.
    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_ALU_M = 2'b01,
        SEL_PC8_M = 2'b10,
        SEL_WDATA = 2'b11
    } fwd_sel_e;

    // -------------------------------------------------------------------------
    // Shadow pipeline state
    // -------------------------------------------------------------------------
    logic [AW-1:0] rs_e_q,   rs_e_d;
    logic [AW-1:0] rt_e_q,   rt_e_d;
    logic [AW-1:0] dst_e_q,  dst_e_d;
    logic [TW-1:0] tnew_e_q, tnew_e_d;
    logic [1:0]    wsrc_e_q, wsrc_e_d;

    logic [AW-1:0] rt_m_q,   rt_m_d;
    logic [AW-1:0] dst_m_q,  dst_m_d;
    logic [TW-1:0] tnew_m_q, tnew_m_d;
    logic [1:0]    wsrc_m_q, wsrc_m_d;

    logic [AW-1:0] dst_w_q,  dst_w_d;

    // Forwarding availability of the M-stage producer.
    logic          m_fwd_ok;
    logic [1:0]    m_fwd_code;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // A producer at some stage forces a stall when the consumer reads the
    // register it writes and the value appears later than it is needed.
    // Register 0 is never a hazard.
    function automatic logic hazard_hit(
        input logic          use_src,
        input logic [AW-1:0] src,
        input logic [TW-1:0] tuse,
        input logic [AW-1:0] dst,
        input logic [TW-1:0] tnew
    );
        return use_src && (src != '0) && (src == dst) && (tnew > tuse);
    endfunction

    // Select for one D/E-stage source operand. M is checked first because it
    // holds the youngest producer. When M writes the register but its value
    // is not ready yet, the older W value would be stale, so nothing is
    // forwarded; the stall logic or a later stage covers that case.
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] src,
        input logic [AW-1:0] dst_m,
        input logic          m_ok,
        input logic [1:0]    m_code,
        input logic [AW-1:0] dst_w
    );
        logic [1:0] sel;
        sel = SEL_REG;
        if ((src != '0) && (src == dst_m)) begin
            if (m_ok) begin
                sel = m_code;
            end
        end else if ((src != '0) && (src == dst_w)) begin
            sel = SEL_WDATA;
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection and forwarding selects
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb block receives a default
    // at the top so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        m_fwd_ok   = 1'b0;
        m_fwd_code = SEL_REG;
        stall      = 1'b0;
        mf_rs_d_op = SEL_REG;
        mf_rt_d_op = SEL_REG;
        mf_rs_e_op = SEL_REG;
        mf_rt_e_op = SEL_REG;
        mf_rt_m_op = 2'b00;

        // Only ALU and PC+8 results exist in M; a load result needs W.
        if (tnew_m_q == '0) begin
            if (wsrc_m_q == WSRC_ALU) begin
                m_fwd_ok   = 1'b1;
                m_fwd_code = SEL_ALU_M;
            end else if (wsrc_m_q == WSRC_PC8) begin
                m_fwd_ok   = 1'b1;
                m_fwd_code = SEL_PC8_M;
            end
        end

        // E is never a forward source, so both E and M producers can stall.
        stall = hazard_hit(use_rs_d, rs_d, tuse_rs_d, dst_e_q, tnew_e_q)
              | hazard_hit(use_rs_d, rs_d, tuse_rs_d, dst_m_q, tnew_m_q)
              | hazard_hit(use_rt_d, rt_d, tuse_rt_d, dst_e_q, tnew_e_q)
              | hazard_hit(use_rt_d, rt_d, tuse_rt_d, dst_m_q, tnew_m_q);

        mf_rs_d_op = fwd_select(rs_d,   dst_m_q, m_fwd_ok, m_fwd_code, dst_w_q);
        mf_rt_d_op = fwd_select(rt_d,   dst_m_q, m_fwd_ok, m_fwd_code, dst_w_q);
        mf_rs_e_op = fwd_select(rs_e_q, dst_m_q, m_fwd_ok, m_fwd_code, dst_w_q);
        mf_rt_e_op = fwd_select(rt_e_q, dst_m_q, m_fwd_ok, m_fwd_code, dst_w_q);

        // Store data in M can only still be stale w.r.t. the W producer.
        if ((rt_m_q != '0) && (rt_m_q == dst_w_q)) begin
            mf_rt_m_op = 2'b01;
        end
    end

    // The bubble is loaded in the same cycle the PC and F/D register freeze.
    assign flush_e = stall;

    // -------------------------------------------------------------------------
    // Shadow pipeline next state
    // -------------------------------------------------------------------------
    always_comb begin
        rs_e_d   = rs_d;
        rt_e_d   = rt_d;
        dst_e_d  = dst_d;
        tnew_e_d = tnew_d;
        wsrc_e_d = wsrc_d;
        if (stall) begin
            rs_e_d   = '0;
            rt_e_d   = '0;
            dst_e_d  = '0;
            tnew_e_d = '0;
            wsrc_e_d = '0;
        end

        rt_m_d   = rt_e_q;
        dst_m_d  = dst_e_q;
        tnew_m_d = (tnew_e_q == '0) ? '0 : tnew_e_q - TW'(1);
        wsrc_m_d = wsrc_e_q;

        dst_w_d  = dst_m_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // shadow stages sample their predecessors' old values on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            dst_e_q  <= '0;
            tnew_e_q <= '0;
            wsrc_e_q <= '0;
            rt_m_q   <= '0;
            dst_m_q  <= '0;
            tnew_m_q <= '0;
            wsrc_m_q <= '0;
            dst_w_q  <= '0;
        end else begin
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            dst_e_q  <= dst_e_d;
            tnew_e_q <= tnew_e_d;
            wsrc_e_q <= wsrc_e_d;
            rt_m_q   <= rt_m_d;
            dst_m_q  <= dst_m_d;
            tnew_m_q <= tnew_m_d;
            wsrc_m_q <= wsrc_m_d;
            dst_w_q  <= dst_w_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating stall cycle counter
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
